// File: rtl/button_conditioner.sv
// button_conditioner: three independent push-button channels, each with a
// 2-flop synchronizer, a level debouncer and a press / long-press FSM.
// Optional feature macro: BTN_AUTOREPEAT_EN adds an auto-repeat state that
// re-fires the press pulse every REPEAT_CYCLES while a long press is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int REPEAT_CYCLES   = 6750000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [2:0] btn_raw_i,
    output logic [2:0] btn_level_o,
    output logic [2:0] btn_press_o,
    output logic [2:0] btn_long_o
);

    // Counter widths hold the largest value each counter may take.
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);

    // Debounce accepts on the edge where the mismatch run reaches DEBOUNCE_CYCLES.
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_TGT = LW'(LONG_CYCLES);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_TGT = RW'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        LONG   = 2'd2,
        REPEAT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } state_t;
`endif

    // Parameters below 1 would make the counters meaningless.
    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("button_conditioner: cycle parameters must be at least 1");
    end

    // Hold counter stops at LONG_CYCLES so a very long press never wraps.
    function automatic logic [LW-1:0] hold_sat_inc(input logic [LW-1:0] v);
        logic [LW-1:0] r;
        r = (v == LONG_TGT) ? v : v + LW'(1);
        return r;
    endfunction

`ifdef BTN_AUTOREPEAT_EN
    // Repeat counter stops at REPEAT_CYCLES; it is cleared on every repeat pulse.
    function automatic logic [RW-1:0] rep_sat_inc(input logic [RW-1:0] v);
        logic [RW-1:0] r;
        r = (v == REP_TGT) ? v : v + RW'(1);
        return r;
    endfunction
`endif

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic          meta_p0;
        logic          sync_p0;
        logic          lvl_p1;
        logic [DW-1:0] db_cnt_p1;
        state_t        state_p2;
        state_t        state_nxt;
        logic [LW-1:0] hold_cnt_p2;
        logic [LW-1:0] hold_nxt;
        logic          level_q;
        logic          press_q;
        logic          long_q;
        logic          press_nxt;
        logic          long_nxt;
        logic          rise;
`ifdef BTN_AUTOREPEAT_EN
        logic [RW-1:0] rep_cnt_p2;
        logic [RW-1:0] rep_nxt;
`endif

        // ---- stage p0: two-flop synchronizer for the asynchronous raw input
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                meta_p0 <= 1'b0;
                sync_p0 <= 1'b0;
            end else begin
                meta_p0 <= btn_raw_i[c];
                sync_p0 <= meta_p0;
            end
        end

        // ---- stage p1: accept a new level after DEBOUNCE_CYCLES consecutive mismatches
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                lvl_p1    <= 1'b0;
                db_cnt_p1 <= '0;
            end else if (sync_p0 == lvl_p1) begin
                db_cnt_p1 <= '0;
            end else if (db_cnt_p1 == DB_LAST) begin
                lvl_p1    <= sync_p0;
                db_cnt_p1 <= '0;
            end else begin
                db_cnt_p1 <= db_cnt_p1 + DW'(1);
            end
        end

        // A rise is the debounced level going high versus the level already presented.
        assign rise = lvl_p1 & ~level_q;

        // ---- stage p2: press / long-press FSM next-state and pulse decode
        always_comb begin
            state_nxt = state_p2;
            hold_nxt  = hold_cnt_p2;
            press_nxt = 1'b0;
            long_nxt  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_nxt   = rep_cnt_p2;
`endif
            case (state_p2)
                IDLE: begin
                    if (rise) begin
                        state_nxt = HOLD;
                        press_nxt = 1'b1;
                        hold_nxt  = '0;
                    end
                end
                HOLD: begin
                    if (!lvl_p1) begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_sat_inc(hold_cnt_p2);
                        if (hold_nxt == LONG_TGT) begin
                            state_nxt = LONG;
                            long_nxt  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rep_nxt   = '0;
`endif
                        end
                    end
                end
                LONG: begin
                    if (!lvl_p1) begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_sat_inc(hold_cnt_p2);
`ifdef BTN_AUTOREPEAT_EN
                        rep_nxt = rep_sat_inc(rep_cnt_p2);
                        if (rep_nxt == REP_TGT) begin
                            state_nxt = REPEAT;
                            press_nxt = 1'b1;
                            rep_nxt   = '0;
                        end
`endif
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                REPEAT: begin
                    if (!lvl_p1) begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end else begin
                        rep_nxt = rep_sat_inc(rep_cnt_p2);
                        if (rep_nxt == REP_TGT) begin
                            press_nxt = 1'b1;
                            rep_nxt   = '0;
                        end
                    end
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end
            endcase
        end

        // FSM state, counters and registered outputs; reset cancels any pending pulse.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                state_p2    <= IDLE;
                hold_cnt_p2 <= '0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                long_q      <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rep_cnt_p2  <= '0;
`endif
            end else begin
                state_p2    <= state_nxt;
                hold_cnt_p2 <= hold_nxt;
                level_q     <= lvl_p1;
                press_q     <= press_nxt;
                long_q      <= long_nxt;
`ifdef BTN_AUTOREPEAT_EN
                rep_cnt_p2  <= rep_nxt;
`endif
            end
        end

        assign btn_level_o[c] = level_q;
        assign btn_press_o[c] = press_q;
        assign btn_long_o[c]  = long_q;
    end

endmodule
